// File: rtl/can_ram_pkg.sv
// Shared definitions for the CAN message-buffer RAM.
// Contents:
//   LANE_W      width of one byte lane (write-enable granularity)
//   RD_LAT_MIN  shortest supported read latency
//   RD_LAT_MAX  longest supported read latency
//   state_e     clear sequencer state encoding
package can_ram_pkg;

   localparam int LANE_W     = 8;
   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 2;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_e;

endpackage

// File: rtl/can_ram_array.sv
// Bare storage array for the CAN message buffer.
// One write port with byte-lane enables and one registered read port.
// No reset and no control logic; the wrapper decides when ports are used.
// Ports:
//   clk    rising-edge clock
//   we     write strobe
//   waddr  write address (must be < DEPTH when we is high)
//   wdata  write data
//   wbe    byte-lane enables, bit i covers wdata[8i+7:8i]
//   re     read strobe (must only be high for in-range raddr)
//   raddr  read address
//   rdata  registered read data, holds when re is low
module can_ram_array
   import can_ram_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 9,
   parameter int DEPTH      = 512
) (
   input  logic                         clk,
   input  logic                         we,
   input  logic [ADDR_WIDTH-1:0]        waddr,
   input  logic [DATA_WIDTH-1:0]        wdata,
   input  logic [DATA_WIDTH/LANE_W-1:0] wbe,
   input  logic                         re,
   input  logic [ADDR_WIDTH-1:0]        raddr,
   output logic [DATA_WIDTH-1:0]        rdata
);

   localparam int NUM_LANES = DATA_WIDTH / LANE_W;

   logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
   logic [DATA_WIDTH-1:0] rdata_q;

   // Read and write share one edge; the non-blocking update makes a
   // same-address collision return the pre-write word.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < NUM_LANES; i++) begin
            if (wbe[i]) begin
               mem[waddr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
            end
         end
      end
      if (re) begin
         rdata_q <= mem[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/can_msg_ram.sv
// Message-buffer RAM for the CAN controller.
// Wraps can_ram_array with access qualification, address range checks,
// a hardware clear sequencer and a 1- or 2-cycle read output pipeline.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   chipSel     block enable, gates wrEn / rdEn / clrReq
//   wrEn, wrAddr, wrData, wrBe   write port with byte-lane enables
//   rdEn, rdAddr                 read request
//   rdData, rdValid              read result and one-cycle valid strobe
//   clrReq      start a clear of the whole array (IDLE only)
//   busy        clear in progress; all accesses are dropped meanwhile
//   addrErr     one-cycle pulse after an out-of-range access
module can_msg_ram
   import can_ram_pkg::*;
#(
   parameter int                    DATA_WIDTH     = 8,
   parameter int                    ADDR_WIDTH     = 9,
   parameter int                    DEPTH          = 512,
   parameter int                    RD_LATENCY     = 1,
   parameter int                    CLEAR_ON_RESET = 1,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         chipSel,
   input  logic                         wrEn,
   input  logic [ADDR_WIDTH-1:0]        wrAddr,
   input  logic [DATA_WIDTH-1:0]        wrData,
   input  logic [DATA_WIDTH/LANE_W-1:0] wrBe,
   input  logic                         rdEn,
   input  logic [ADDR_WIDTH-1:0]        rdAddr,
   output logic [DATA_WIDTH-1:0]        rdData,
   output logic                         rdValid,
   input  logic                         clrReq,
   output logic                         busy,
   output logic                         addrErr
);

   localparam int NUM_LANES = DATA_WIDTH / LANE_W;
   // Counter is one bit wider than the address so DEPTH == 2**ADDR_WIDTH
   // compares cleanly without wrapping.
   localparam int CNT_W = ADDR_WIDTH + 1;
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(DEPTH - 1);
   // Anything other than the long latency falls back to the short one.
   localparam int RD_LAT = (RD_LATENCY > RD_LAT_MIN) ? RD_LAT_MAX : RD_LAT_MIN;
   localparam state_e RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
   localparam logic   RST_BUSY  = (CLEAR_ON_RESET != 0);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             vld_p1_q, vld_p1_d;
   logic             zero_p1_q, zero_p1_d;
   logic             err_q, err_d;

   logic wr_req, rd_req;
   logic wr_in_range, rd_in_range;
   logic wr_acc, rd_acc;
   logic wr_oor, rd_oor;
   logic clearing;

   logic                         arr_we;
   logic [ADDR_WIDTH-1:0]        arr_waddr;
   logic [DATA_WIDTH-1:0]        arr_wdata;
   logic [NUM_LANES-1:0]         arr_wbe;
   logic                         arr_re;
   logic [DATA_WIDTH-1:0]        arr_rdata;
   logic [DATA_WIDTH-1:0]        rd_data_p1;

   // Access qualification: everything is dropped while the clear runs.
   assign wr_req      = chipSel & wrEn & ~busy_q;
   assign rd_req      = chipSel & rdEn & ~busy_q;
   assign wr_in_range = ({1'b0, wrAddr} < DEPTH_CNT);
   assign rd_in_range = ({1'b0, rdAddr} < DEPTH_CNT);
   assign wr_acc      = wr_req & wr_in_range;
   assign rd_acc      = rd_req;
   assign wr_oor      = wr_req & ~wr_in_range;
   assign rd_oor      = rd_req & ~rd_in_range;
   assign clearing    = (state_q == ST_CLEAR);

   // Clear sequencer next state.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      case (state_q)
         ST_IDLE: begin
            if (chipSel && clrReq) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
               busy_d  = 1'b1;
            end
         end
         ST_CLEAR: begin
            if (cnt_q == LAST_CNT) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               busy_d  = 1'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // Stage 0 -> 1: read accept, out-of-range bookkeeping.
   // An out-of-range read never touches the array; the zero flag masks the
   // stale array register instead, and also gives rdData its reset value.
   always_comb begin
      vld_p1_d  = rd_acc;
      zero_p1_d = zero_p1_q;
      if (rd_acc) begin
         zero_p1_d = ~rd_in_range;
      end
      // OR of both ports so a double violation yields a single pulse.
      err_d = wr_oor | rd_oor;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= RST_STATE;
         cnt_q     <= '0;
         busy_q    <= RST_BUSY;
         vld_p1_q  <= 1'b0;
         zero_p1_q <= 1'b1;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         vld_p1_q  <= vld_p1_d;
         zero_p1_q <= zero_p1_d;
         err_q     <= err_d;
      end
   end

   // The clear sequencer owns the write port while it runs; wr_acc is
   // already low then because busy gates it.
   assign arr_we    = clearing | wr_acc;
   assign arr_waddr = clearing ? cnt_q[ADDR_WIDTH-1:0] : wrAddr;
   assign arr_wdata = clearing ? CLEAR_VALUE : wrData;
   assign arr_wbe   = clearing ? {NUM_LANES{1'b1}} : wrBe;
   assign arr_re    = rd_acc & rd_in_range;

   can_ram_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH)
   ) u_array (
      .clk   (clk),
      .we    (arr_we),
      .waddr (arr_waddr),
      .wdata (arr_wdata),
      .wbe   (arr_wbe),
      .re    (arr_re),
      .raddr (rdAddr),
      .rdata (arr_rdata)
   );

   assign rd_data_p1 = zero_p1_q ? '0 : arr_rdata;

   // Stage 1 -> 2: optional output register.
   generate
      if (RD_LAT == RD_LAT_MAX) begin : g_lat2
         logic [DATA_WIDTH-1:0] data_p2_q, data_p2_d;
         logic                  vld_p2_q, vld_p2_d;

         always_comb begin
            data_p2_d = data_p2_q;
            if (vld_p1_q) begin
               data_p2_d = rd_data_p1;
            end
            vld_p2_d = vld_p1_q;
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               data_p2_q <= '0;
               vld_p2_q  <= 1'b0;
            end else begin
               data_p2_q <= data_p2_d;
               vld_p2_q  <= vld_p2_d;
            end
         end

         assign rdData  = data_p2_q;
         assign rdValid = vld_p2_q;
      end else begin : g_lat1
         assign rdData  = rd_data_p1;
         assign rdValid = vld_p1_q;
      end
   endgenerate

   assign busy    = busy_q;
   assign addrErr = err_q;

endmodule

// File: tb/tb_can_msg_ram.sv
// Directed bench for can_msg_ram with two configurations:
//   dut A: 16-bit words, DEPTH 512, latency 1, clear on reset
//   dut B: 8-bit words, DEPTH 300, latency 2, no clear on reset
module tb_can_msg_ram;

   logic clk;
   logic rst_a_n, rst_b_n;

   logic        a_cs, a_we, a_re, a_clr;
   logic [8:0]  a_wa, a_ra;
   logic [15:0] a_wd;
   logic [1:0]  a_be;
   logic [15:0] a_rd;
   logic        a_rv, a_busy, a_err;

   logic        b_cs, b_we, b_re, b_clr;
   logic [8:0]  b_wa, b_ra;
   logic [7:0]  b_wd;
   logic [0:0]  b_be;
   logic [7:0]  b_rd;
   logic        b_rv, b_busy, b_err;

   int total = 0;
   int bad   = 0;

   can_msg_ram #(
      .DATA_WIDTH(16), .ADDR_WIDTH(9), .DEPTH(512),
      .RD_LATENCY(1), .CLEAR_ON_RESET(1), .CLEAR_VALUE(16'h0000)
   ) u_dut_a (
      .clk(clk), .rst_n(rst_a_n), .chipSel(a_cs),
      .wrEn(a_we), .wrAddr(a_wa), .wrData(a_wd), .wrBe(a_be),
      .rdEn(a_re), .rdAddr(a_ra), .rdData(a_rd), .rdValid(a_rv),
      .clrReq(a_clr), .busy(a_busy), .addrErr(a_err)
   );

   can_msg_ram #(
      .DATA_WIDTH(8), .ADDR_WIDTH(9), .DEPTH(300),
      .RD_LATENCY(2), .CLEAR_ON_RESET(0), .CLEAR_VALUE(8'h00)
   ) u_dut_b (
      .clk(clk), .rst_n(rst_b_n), .chipSel(b_cs),
      .wrEn(b_we), .wrAddr(b_wa), .wrData(b_wd), .wrBe(b_be),
      .rdEn(b_re), .rdAddr(b_ra), .rdData(b_rd), .rdValid(b_rv),
      .clrReq(b_clr), .busy(b_busy), .addrErr(b_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic a_write(input logic [8:0] addr, input logic [15:0] data, input logic [1:0] be);
      a_we = 1'b1; a_wa = addr; a_wd = data; a_be = be;
      tick();
      a_we = 1'b0;
   endtask

   task automatic a_read(input logic [8:0] addr, input logic [15:0] exp, input string tag);
      a_re = 1'b1; a_ra = addr;
      tick();
      a_re = 1'b0;
      chk({tag, "_vld"}, a_rv, 1);
      chk(tag, a_rd, exp);
   endtask

   task automatic b_write(input logic [8:0] addr, input logic [7:0] data);
      b_we = 1'b1; b_wa = addr; b_wd = data; b_be = 1'b1;
      tick();
      b_we = 1'b0;
   endtask

   task automatic b_read(input logic [8:0] addr, input logic [7:0] exp, input string tag);
      b_re = 1'b1; b_ra = addr;
      tick();
      b_re = 1'b0;
      tick();
      chk({tag, "_vld"}, b_rv, 1);
      chk(tag, b_rd, exp);
   endtask

   task automatic count_busy_a(output int n);
      n = 0;
      while (a_busy && n < 2000) begin
         n++;
         tick();
      end
   endtask

   initial begin
      int n;
      rst_a_n = 1'b0; rst_b_n = 1'b0;
      a_cs = 1'b1; a_we = 1'b0; a_re = 1'b0; a_clr = 1'b0;
      a_wa = '0; a_ra = '0; a_wd = '0; a_be = '0;
      b_cs = 1'b1; b_we = 1'b0; b_re = 1'b0; b_clr = 1'b0;
      b_wa = '0; b_ra = '0; b_wd = '0; b_be = '0;
      repeat (3) tick();

      // reset values
      chk("a_rst_rd",   a_rd,   0);
      chk("a_rst_vld",  a_rv,   0);
      chk("a_rst_err",  a_err,  0);
      chk("a_rst_busy", a_busy, 1);
      chk("b_rst_rd",   b_rd,   0);
      chk("b_rst_vld",  b_rv,   0);
      chk("b_rst_busy", b_busy, 0);

      rst_a_n = 1'b1; rst_b_n = 1'b1;
      count_busy_a(n);
      chk("a_clr_cycles", n, 512);

      a_read(9'd0,   16'h0000, "a_clr_0");
      a_read(9'd255, 16'h0000, "a_clr_255");
      a_read(9'd511, 16'h0000, "a_clr_511");

      // byte lanes
      a_write(9'd5, 16'hABCD, 2'b11);
      a_write(9'd5, 16'h1234, 2'b01);
      a_read(9'd5, 16'hAB34, "a_lane");
      a_write(9'd5, 16'hFFFF, 2'b00);
      a_read(9'd5, 16'hAB34, "a_be_zero");
      a_cs = 1'b0;
      a_write(9'd5, 16'h5555, 2'b11);
      a_re = 1'b1; a_ra = 9'd5;
      tick();
      a_re = 1'b0;
      chk("a_cs_off_vld", a_rv, 0);
      a_cs = 1'b1;
      a_read(9'd5, 16'hAB34, "a_cs_off_wr");

      // read-first collision
      a_write(9'd7, 16'h0011, 2'b11);
      a_we = 1'b1; a_wa = 9'd7; a_wd = 16'h0022; a_be = 2'b11;
      a_re = 1'b1; a_ra = 9'd7;
      tick();
      a_we = 1'b0; a_re = 1'b0;
      chk("a_rf_vld", a_rv, 1);
      chk("a_rf_old", a_rd, 16'h0011);
      a_read(9'd7, 16'h0022, "a_rf_new");
      tick();
      chk("a_hold_vld", a_rv, 0);
      chk("a_hold_rd",  a_rd, 16'h0022);

      // clear request with a read in flight, then dropped accesses
      a_clr = 1'b1; a_re = 1'b1; a_ra = 9'd5;
      tick();
      a_clr = 1'b0; a_re = 1'b0;
      chk("a_flight_vld", a_rv, 1);
      chk("a_flight_rd",  a_rd, 16'hAB34);
      chk("a_clr_busy",   a_busy, 1);
      a_re = 1'b1; a_ra = 9'd7;
      a_we = 1'b1; a_wa = 9'd7; a_wd = 16'h9999; a_be = 2'b11;
      tick();
      a_re = 1'b0; a_we = 1'b0;
      chk("a_busy_drop_vld", a_rv, 0);
      chk("a_busy_drop_rd",  a_rd, 16'hAB34);
      repeat (99) tick();
      chk("a_mid_busy", a_busy, 1);

      // reset mid-clear
      rst_a_n = 1'b0;
      #1;
      chk("a_mid_rst_rd",   a_rd,   0);
      chk("a_mid_rst_vld",  a_rv,   0);
      chk("a_mid_rst_err",  a_err,  0);
      chk("a_mid_rst_busy", a_busy, 1);
      repeat (2) tick();
      rst_a_n = 1'b1;
      count_busy_a(n);
      chk("a_reclr_cycles", n, 512);
      a_read(9'd5, 16'h0000, "a_reclr_5");

      // dut B: requested clear
      b_clr = 1'b1;
      tick();
      b_clr = 1'b0;
      n = 0;
      while (b_busy && n < 2000) begin
         n++;
         tick();
      end
      chk("b_clr_cycles", n, 300);

      b_write(9'd0, 8'hA0);
      b_write(9'd1, 8'hA1);
      b_write(9'd2, 8'hA2);
      b_write(9'd54, 8'h5A);
      b_write(9'd299, 8'h77);

      // latency 2 streaming
      for (int k = 0; k < 5; k++) begin
         b_re = (k < 3);
         b_ra = 9'(k);
         tick();
         chk($sformatf("b_stream_vld%0d", k), b_rv, (k >= 1 && k <= 3) ? 1 : 0);
         if (k >= 1 && k <= 3) chk($sformatf("b_stream_rd%0d", k), b_rd, 8'hA0 + 8'(k - 1));
      end
      b_re = 1'b0;
      chk("b_stream_hold", b_rd, 8'hA2);

      b_read(9'd299, 8'h77, "b_last");

      // out-of-range accesses
      b_write(9'd310, 8'hEE);
      chk("b_oor_wr_err", b_err, 1);
      tick();
      chk("b_oor_wr_err_end", b_err, 0);
      b_re = 1'b1; b_ra = 9'd310;
      tick();
      b_re = 1'b0;
      chk("b_oor_rd_err", b_err, 1);
      tick();
      chk("b_oor_rd_err_end", b_err, 0);
      chk("b_oor_rd_vld", b_rv, 1);
      chk("b_oor_rd_data", b_rd, 0);
      b_read(9'd54, 8'h5A, "b_alias");

      b_we = 1'b1; b_wa = 9'd305; b_wd = 8'h33; b_be = 1'b1;
      b_re = 1'b1; b_ra = 9'd320;
      tick();
      b_we = 1'b0; b_re = 1'b0;
      chk("b_dual_err", b_err, 1);
      tick();
      chk("b_dual_err_end", b_err, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected done");
      $fatal(1, "timeout");
   end

endmodule
